// File: rtl/icache_refill_responder_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : icache_refill_responder_if
// Purpose : Request, response and memory-port bundle of the icache refill responder.
// Revision: 1.0 - initial release
// ============================================================================
interface icache_refill_responder_if #(
    parameter int XLEN       = 32,
    parameter int LINE_WIDTH = 256
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic [XLEN-1:0]       req_addr_i;
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [XLEN-1:0]       rsp_addr_o;
    logic [LINE_WIDTH-1:0] rsp_data_o;
    logic                  rsp_err_o;
    logic                  flush_i;
    logic                  mem_req_valid_o;
    logic                  mem_req_ready_i;
    logic [XLEN-1:0]       mem_req_addr_o;
    logic                  mem_rsp_valid_i;
    logic [XLEN-1:0]       mem_rsp_data_i;
    logic                  mem_rsp_err_i;

    // Responder side
    modport slave (
        input  req_valid_i, req_addr_i, rsp_ready_i, flush_i,
               mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i, mem_rsp_err_i,
        output req_ready_o, rsp_valid_o, rsp_addr_o, rsp_data_o, rsp_err_o,
               mem_req_valid_o, mem_req_addr_o
    );

    // Icache / memory side
    modport master (
        output req_valid_i, req_addr_i, rsp_ready_i, flush_i,
               mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i, mem_rsp_err_i,
        input  req_ready_o, rsp_valid_o, rsp_addr_o, rsp_data_o, rsp_err_o,
               mem_req_valid_o, mem_req_addr_o
    );
endinterface
`default_nettype wire

// File: rtl/icache_refill_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : icache_refill_responder
// Purpose : Turns one icache line miss into word reads and returns the full line.
//           Define ICACHE_REFILL_CWF_EN for critical-word-first read order.
// Revision: 1.0 - initial release
// ============================================================================
module icache_refill_responder #(
    parameter int XLEN            = 32,
    parameter int LINE_WIDTH      = 256,
    parameter int MAX_OUTSTANDING = 4
) (
    input logic                      clk_i,
    input logic                      rst_ni,
    icache_refill_responder_if.slave bus
);
    localparam int WORDS  = LINE_WIDTH / XLEN;
    localparam int OFF_W  = $clog2(LINE_WIDTH / 8);
    localparam int BYTE_W = $clog2(XLEN / 8);
    localparam int IDX_W  = $clog2(WORDS);
    localparam int CNT_W  = IDX_W + 1;
    localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int TAG_W  = XLEN - OFF_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                state, state_next;
    logic [TAG_W-1:0]      base_tag;
    logic [CNT_W-1:0]      issue_cnt, rx_cnt;
    logic [OUT_W-1:0]      outstanding, outstanding_next;
    logic [LINE_WIDTH-1:0] line;
    logic                  err;
    logic [IDX_W-1:0]      issue_idx, rx_idx;
    logic                  accept, issue_en, issue_fire, rsp_fire, last_beat;
    logic                  req_ready, rsp_valid;
    logic                  unused_addr_low;

`ifdef ICACHE_REFILL_CWF_EN
    logic [IDX_W-1:0] start_idx;
    // Modulo-WORDS wrap falls out of the IDX_W-bit addition
    assign issue_idx = start_idx + issue_cnt[IDX_W-1:0];
    assign rx_idx    = start_idx + rx_cnt[IDX_W-1:0];
`else
    assign issue_idx = issue_cnt[IDX_W-1:0];
    assign rx_idx    = rx_cnt[IDX_W-1:0];
`endif

    assign unused_addr_low = ^bus.req_addr_i[OFF_W-1:0];

    assign accept     = (state == IDLE) && bus.req_valid_i;
    assign issue_en   = (state == FILL) && !bus.flush_i &&
                        (issue_cnt < CNT_W'(WORDS)) &&
                        (outstanding < OUT_W'(MAX_OUTSTANDING));
    assign issue_fire = issue_en && bus.mem_req_ready_i;
    assign rsp_fire   = bus.mem_rsp_valid_i && ((state == FILL) || (state == DRAIN));
    assign last_beat  = rsp_fire && (rx_cnt == CNT_W'(WORDS - 1));
    assign outstanding_next = outstanding + OUT_W'(issue_fire) - OUT_W'(rsp_fire);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid_i) state_next = FILL;
            end
            FILL: begin
                if (bus.flush_i) begin
                    state_next = (outstanding_next == '0) ? IDLE : DRAIN;
                end else if (last_beat) begin
                    state_next = RESP;
                end
            end
            DRAIN: begin
                if (outstanding_next == '0) state_next = IDLE;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (bus.flush_i || bus.rsp_ready_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            base_tag    <= '0;
            issue_cnt   <= '0;
            rx_cnt      <= '0;
            outstanding <= '0;
            line        <= '0;
            err         <= 1'b0;
`ifdef ICACHE_REFILL_CWF_EN
            start_idx   <= '0;
`endif
        end else if (accept) begin
            base_tag    <= bus.req_addr_i[XLEN-1:OFF_W];
            issue_cnt   <= '0;
            rx_cnt      <= '0;
            outstanding <= '0;
            err         <= 1'b0;
`ifdef ICACHE_REFILL_CWF_EN
            start_idx   <= bus.req_addr_i[OFF_W-1:BYTE_W];
`endif
        end else begin
            outstanding <= outstanding_next;
            if (issue_fire) issue_cnt <= issue_cnt + CNT_W'(1);
            // Beats returning in DRAIN belong to a flushed line and are dropped
            if (rsp_fire && (state == FILL)) begin
                rx_cnt <= rx_cnt + CNT_W'(1);
                err    <= err | bus.mem_rsp_err_i;
                for (int k = 0; k < WORDS; k++) begin
                    if (rx_idx == IDX_W'(k)) line[k*XLEN +: XLEN] <= bus.mem_rsp_data_i;
                end
            end
        end
    end

    assign bus.req_ready_o     = req_ready;
    assign bus.rsp_valid_o     = rsp_valid;
    assign bus.rsp_addr_o      = {base_tag, {OFF_W{1'b0}}};
    assign bus.rsp_data_o      = line;
    assign bus.rsp_err_o       = err;
    assign bus.mem_req_valid_o = issue_en;
    assign bus.mem_req_addr_o  = {base_tag, issue_idx, {BYTE_W{1'b0}}};

`ifndef SYNTHESIS
    stray_mem_rsp: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.mem_rsp_valid_i |-> ((state == FILL) || (state == DRAIN)));
`endif
endmodule
`default_nettype wire

// File: tb/tb_icache_refill_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_icache_refill_responder
// Purpose : Scoreboard bench for the icache refill responder with a memory model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_icache_refill_responder;
    localparam int XLEN = 32, LINE_WIDTH = 256, WORDS = 8, MAX_OUT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0, errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    icache_refill_responder_if #(.XLEN(XLEN), .LINE_WIDTH(LINE_WIDTH)) bus ();

    icache_refill_responder #(
        .XLEN(XLEN), .LINE_WIDTH(LINE_WIDTH), .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus.slave)
    );

    typedef struct { logic [31:0] addr; logic [255:0] data; logic err; } exp_t;
    typedef struct { logic [31:0] addr; int beat; int due; } pend_t;
    exp_t  exp_q[$];
    pend_t pq[$];

    // Memory model knobs
    int          delay = 1, gap = 1, stall_beat = -1, stall_len = 0, issue_limit = 99, err_beat = -1;
    logic [31:0] salt = '0;
    int          issued_in_req = 0, stalled = 0, last_due = 0;

    // Monitor state
    int          mon_out = 0, mon_issued = 0, max_out_seen = 0, first_rsp_cyc = -1, acc_cyc = 0;
    logic [31:0] cur_base = '0;
    logic [2:0]  cur_start = '0;
    logic        prev_mstall = 1'b0, prev_rstall = 1'b0, prev_rerr = 1'b0;
    logic [31:0] prev_maddr = '0, prev_raddr = '0;
    logic [255:0] prev_rdata = '0;
    exp_t        e;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] word_addr(input int n);
        logic [2:0] idx;
        idx = n[2:0];
`ifdef ICACHE_REFILL_CWF_EN
        idx = idx + cur_start;
`endif
        return {cur_base[31:5], idx, 2'b00};
    endfunction

    // Memory model: in-order responses, configurable latency, gap, stalls and error beat
    initial begin : mem_model
        logic        hs, fire, acc;
        logic [31:0] a;
        int          due;
        bus.mem_req_ready_i = 1'b1;
        bus.mem_rsp_valid_i = 1'b0;
        bus.mem_rsp_data_i  = '0;
        bus.mem_rsp_err_i   = 1'b0;
        forever begin
            @(negedge clk);
            hs   = rst_n && bus.mem_req_valid_o && bus.mem_req_ready_i;
            a    = bus.mem_req_addr_o;
            fire = rst_n && bus.mem_rsp_valid_i;
            acc  = rst_n && bus.req_valid_i && bus.req_ready_o;
            @(posedge clk); #1;
            if (!rst_n) begin
                pq.delete();
                issued_in_req = 0;
                stalled = 0;
            end else begin
                if (acc) begin issued_in_req = 0; stalled = 0; end
                if (fire && pq.size() > 0) void'(pq.pop_front());
                if (hs) begin
                    due = cyc + delay - 1;
                    if (due < last_due + gap) due = last_due + gap;
                    last_due = due;
                    pq.push_back('{a, issued_in_req, due});
                    issued_in_req++;
                end
            end
            if (issued_in_req >= issue_limit) bus.mem_req_ready_i = 1'b0;
            else if (issued_in_req == stall_beat && stalled < stall_len && bus.mem_req_valid_o) begin
                bus.mem_req_ready_i = 1'b0;
                stalled++;
            end else bus.mem_req_ready_i = 1'b1;
            if (rst_n && pq.size() > 0 && pq[0].due <= cyc) begin
                bus.mem_rsp_valid_i = 1'b1;
                bus.mem_rsp_data_i  = pq[0].addr ^ salt;
                bus.mem_rsp_err_i   = (pq[0].beat == err_beat);
            end else begin
                bus.mem_rsp_valid_i = 1'b0;
                bus.mem_rsp_data_i  = '0;
                bus.mem_rsp_err_i   = 1'b0;
            end
        end
    end

    // Monitor / scoreboard
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_out = 0; mon_issued = 0;
                prev_mstall = 1'b0; prev_rstall = 1'b0;
                exp_q.delete();
            end else begin
                if (prev_mstall && !bus.flush_i) begin
                    check("mem_req_valid held while stalled", bus.mem_req_valid_o, 1);
                    check("mem_req_addr held while stalled", bus.mem_req_addr_o, prev_maddr);
                end
                if (bus.req_valid_i && bus.req_ready_o) begin
                    cur_base = bus.req_addr_i & 32'hFFFF_FFE0;
                    cur_start = bus.req_addr_i[4:2];
                    mon_issued = 0;
                    first_rsp_cyc = -1;
                end
                if (bus.mem_req_valid_o && bus.mem_req_ready_i) begin
                    check("mem_req_addr order", bus.mem_req_addr_o, word_addr(mon_issued));
                    check("reads in flight below limit", mon_out < MAX_OUT, 1);
                    mon_issued++;
                    mon_out++;
                end
                if (bus.mem_rsp_valid_i) mon_out--;
                if (mon_out > max_out_seen) max_out_seen = mon_out;
                if (bus.rsp_valid_o) begin
                    if (first_rsp_cyc < 0) first_rsp_cyc = cyc;
                    if (prev_rstall) begin
                        check("rsp_addr held", bus.rsp_addr_o, prev_raddr);
                        check("rsp_data held", bus.rsp_data_o, prev_rdata);
                        check("rsp_err held", bus.rsp_err_o, prev_rerr);
                    end
                    if (exp_q.size() == 0) begin
                        check("rsp_valid with no pending line", bus.rsp_valid_o, 0);
                    end else if (bus.rsp_ready_i) begin
                        e = exp_q.pop_front();
                        check("rsp_addr", bus.rsp_addr_o, e.addr);
                        check("rsp_data", bus.rsp_data_o, e.data);
                        check("rsp_err", bus.rsp_err_o, e.err);
                        check("req_ready low during response", bus.req_ready_o, 0);
                    end
                end
                prev_mstall = bus.mem_req_valid_o && !bus.mem_req_ready_i;
                prev_maddr  = bus.mem_req_addr_o;
                prev_rstall = bus.rsp_valid_o && !bus.rsp_ready_i;
                prev_raddr  = bus.rsp_addr_o;
                prev_rdata  = bus.rsp_data_o;
                prev_rerr   = bus.rsp_err_o;
            end
        end
    end

    task automatic do_req(input logic [31:0] addr, input logic [31:0] s, input int ebeat, input bit expect_line);
        exp_t x;
        int   n = 0;
        @(posedge clk); #1;
        while (!bus.req_ready_o && n < 100) begin @(posedge clk); #1; n++; end
        check("req_ready before request", bus.req_ready_o, 1);
        salt = s;
        err_beat = ebeat;
        if (expect_line) begin
            x.addr = addr & 32'hFFFF_FFE0;
            for (int k = 0; k < WORDS; k++) x.data[k*32 +: 32] = (x.addr + 32'(4 * k)) ^ s;
            x.err = (ebeat >= 0 && ebeat < WORDS);
            exp_q.push_back(x);
        end
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = addr;
        acc_cyc = cyc;
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin @(posedge clk); n++; end
        check({name, " line delivered"}, exp_q.size() == 0, 1);
        @(negedge clk);
        check({name, " req_ready after handshake"}, bus.req_ready_o, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_ready"}, bus.req_ready_o, 1);
        check({tag, " rsp_valid"}, bus.rsp_valid_o, 0);
        check({tag, " mem_req_valid"}, bus.mem_req_valid_o, 0);
        check({tag, " rsp_err"}, bus.rsp_err_o, 0);
        check({tag, " rsp_addr"}, bus.rsp_addr_o, 0);
        check({tag, " rsp_data"}, bus.rsp_data_o, 0);
    endtask

    initial begin : stimulus
        int n;
        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = '0;
        bus.rsp_ready_i = 1'b1;
        bus.flush_i     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Basic refill, zero-wait memory
        do_req(32'h8000_0014, 32'h0, -1, 1);
        wait_done("basic", 100);
        check("basic rsp latency", first_rsp_cyc - acc_cyc, WORDS + 2);

        // Memory stall on beat 2, long read latency, icache backpressure
        delay = 8; stall_beat = 2; stall_len = 3; max_out_seen = 0;
        bus.rsp_ready_i = 1'b0;
        do_req(32'h0000_4020, 32'h5A5A_0000, -1, 1);
        n = 0;
        while (!bus.rsp_valid_o && n < 300) begin @(posedge clk); #1; n++; end
        check("backpressure rsp_valid seen", bus.rsp_valid_o, 1);
        repeat (5) @(posedge clk);
        #1;
        bus.rsp_ready_i = 1'b1;
        wait_done("backpressure", 100);
        check("backpressure peak reads in flight", max_out_seen, MAX_OUT);
        delay = 1; stall_beat = -1; stall_len = 0;

        // Error on beat 5, then a clean refill
        do_req(32'h0000_2000, 32'h1111_0000, 5, 1);
        wait_done("error", 100);
        do_req(32'h0000_2044, 32'h2222_0000, -1, 1);
        wait_done("clean after error", 100);

        // Flush after 3 issues and 1 response, while the 4th read is stalled
        delay = 2; gap = 3; issue_limit = 3;
        do_req(32'h0000_3000, 32'h0, -1, 0);
        repeat (4) @(posedge clk);
        #1;
        bus.flush_i = 1'b1;
        @(negedge clk);
        check("flush mem_req_valid", bus.mem_req_valid_o, 0);
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        @(negedge clk);
        check("drain req_ready", bus.req_ready_o, 0);
        check("drain mem_req_valid", bus.mem_req_valid_o, 0);
        n = 0;
        while (!bus.req_ready_o && n < 50) begin @(negedge clk); n++; end
        check("flush back to idle", bus.req_ready_o, 1);
        check("flush responses drained", mon_out, 0);
        check("flush no further issues", mon_issued, 3);
        delay = 1; gap = 1; issue_limit = 99;

        // Miss in the middle of a line (critical-word-first order when enabled)
        do_req(32'h0000_1018, 32'h3333_0000, -1, 1);
        wait_done("mid-line miss", 100);

        // Asynchronous reset in the middle of a fill
        delay = 6;
        do_req(32'h0000_5008, 32'h4444_0000, -1, 1);
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        delay = 1;
        do_req(32'h0000_6004, 32'h5555_0000, -1, 1);
        wait_done("after reset", 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/icache_refill_responder.md
Name: icache_refill_responder

Overview:
- Memory-side responder for instruction-cache line refills: accepts one line-miss request from the icache and issues XLEN-wide word reads to the backing memory port.
- Assembles the returned words into one full cache line and returns it to the icache over a valid/ready response channel.
- Sits between the icache miss path and the memory/bus bridge. Sized from the core config: XLEN 32, 256-bit line.

Parameters:
- XLEN, 32, data/address width of the memory word port.
- LINE_WIDTH, 256, cache line width in bits; must be a multiple of XLEN; LINE_WIDTH/XLEN must be a power of two ≥2.
- WORDS (localparam), LINE_WIDTH/XLEN = 8, beats per line.
- OFF_W (localparam), log2(LINE_WIDTH/8) = 5, line-offset bits.
- MAX_OUTSTANDING, 4, maximum word reads in flight (1..WORDS).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  icache miss request valid
- req_ready_o  out  1  responder can accept a request
- req_addr_i  in  XLEN  miss address (any byte in line)
- rsp_valid_o  out  1  refilled line valid
- rsp_ready_i  in  1  icache accepts line
- rsp_addr_o  out  XLEN  line-aligned address of returned line
- rsp_data_o  out  LINE_WIDTH  line data; word k at bits [k*XLEN +: XLEN]
- rsp_err_o  out  1  any beat returned error
- flush_i  in  1  abort current refill (pipeline redirect/fence.i)
- mem_req_valid_o  out  1  word read request
- mem_req_ready_i  in  1  memory accepts word read
- mem_req_addr_o  out  XLEN  word-aligned read address
- mem_rsp_valid_i  in  1  word read data valid; in order; always accepted
- mem_rsp_data_i  in  XLEN  read data
- mem_rsp_err_i  in  1  bus error on this beat

Behaviour:
- Clock clk_i; reset rst_ni is asynchronous and active-low. Reset: state IDLE, all counters 0, req_ready_o=1, rsp_valid_o=0, mem_req_valid_o=0, rsp_err_o=0, rsp_addr_o=0, rsp_data_o=0.
- States: IDLE, FILL, DRAIN, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i&req_ready_o: latch base = req_addr_i with low OFF_W bits cleared; latch start_idx = req_addr_i[OFF_W-1:2]; clear issue_cnt, rx_cnt, outstanding, err; go FILL.
- FILL:
  - req_ready_o=0.
  - mem_req_valid_o = (issue_cnt<WORDS) && (outstanding<MAX_OUTSTANDING).
  - mem_req_addr_o = base + (word_idx(issue_cnt) << 2); word_idx(n) = n in base build.
  - mem_req_valid_o/addr stay stable until mem_req_ready_i.
  - Issue handshake: issue_cnt+1, outstanding+1.
  - Each mem_rsp_valid_i: write data into slot word_idx(rx_cnt); rx_cnt+1, outstanding-1; err |= mem_rsp_err_i.
  - Issue and response in the same cycle: outstanding unchanged.
  - When the final beat arrives (rx_cnt becomes WORDS): go RESP next cycle.
- RESP:
  - rsp_valid_o=1; rsp_addr_o=base, rsp_data_o, rsp_err_o held stable until rsp_ready_i.
  - On handshake: go IDLE. req_ready_o goes 1 the following cycle; no same-cycle accept.
- flush_i:
  - In FILL: stop issuing immediately; mem_req_valid_o=0 that same cycle, even mid-stall.
  - If outstanding (after this cycle's updates) is 0, go IDLE; otherwise go DRAIN.
  - In DRAIN: accept and discard responses until outstanding=0, then IDLE. No rsp_valid_o is produced for a flushed line.
  - In RESP: drops the pending line and goes IDLE.
  - In IDLE or DRAIN: no effect.
  - A request arriving in the same cycle as flush_i in IDLE is accepted; flush takes effect only from FILL onward.
- mem_rsp_valid_i in IDLE or RESP is a protocol violation: ignored; assertion fires in simulation.
- Reset mid-operation: everything returns to reset values at once; later stray memory responses are ignored.
- Latency with zero-wait memory and 1-cycle response: request accept → rsp_valid_o = WORDS + 2 cycles.

Optional Feature:
- Macro ICACHE_REFILL_CWF_EN selects critical-word-first ordering.
- Defined: word_idx(n) = (start_idx + n) mod WORDS. The first memory read is the missed word, and addresses wrap within the line. Returned data is still placed in natural slot order on rsp_data_o.
- Not defined: word_idx(n) = n, so reads go from base upward and start_idx is unused.

Test Plan:
- Basic refill: req_addr 0x8000_0014, zero-wait memory returning data=addr → mem addrs 0x8000_0000..0x8000_001C in order; rsp_addr_o=0x8000_0000; word k = 0x8000_0000+4k; rsp_valid_o 10 cycles after accept.
- Backpressure: mem_req_ready_i low for 3 cycles on beat 2, rsp_ready_i low 5 cycles → addr stable while stalled; ≤MAX_OUTSTANDING(4) reads in flight; line held unchanged until accepted.
- Error: mem_rsp_err_i=1 on beat 5 only → rsp_err_o=1 with the line; next refill without errors → rsp_err_o=0.
- Flush: flush_i after 3 issues, 1 response received → no further mem_req_valid_o; 2 remaining responses absorbed in DRAIN; no rsp_valid_o; IDLE, req_ready_o=1 afterwards.
- CWF (ICACHE_REFILL_CWF_EN): req_addr 0x0000_1018 → issue order 0x1018, 0x101C, 0x1000..0x1014; rsp_data_o slots in natural order.
- Async reset asserted mid-FILL → all outputs at reset values before the next clock edge; a new request after release completes normally.
